// File: rtl/vend_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// vend_sequencer_pkg
// Shared definitions for the vending transaction controller: state encoding,
// item codes, the largest displayable amount and the two-digit range check.
// -----------------------------------------------------------------------------
package vend_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SHOP     = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_CHANGE   = 2'd3
   } vend_state_t;

   localparam logic [1:0] ITEM_BISCUIT = 2'd0;
   localparam logic [1:0] ITEM_BERRY   = 2'd1;
   localparam logic [1:0] ITEM_MILK    = 2'd2;
   localparam logic [1:0] ITEM_COFFEE  = 2'd3;

   localparam logic [6:0] MAX_AMOUNT = 7'd99;

   // True when total + amount still fits the two-digit displays. The sum is
   // formed in 8 bits so that 7-bit wrap-around cannot hide an overflow.
   function automatic logic fits_99(input logic [6:0] total, input logic [6:0] amount);
      return ({1'b0, total} + {1'b0, amount}) <= {1'b0, MAX_AMOUNT};
   endfunction

endpackage

// File: rtl/vend_sequencer_bin2bcd99.sv
// -----------------------------------------------------------------------------
// bin2bcd99
// Combinational binary to two-digit BCD conversion for amounts 0..99.
// Ports:
//   bin   in  7  binary amount (0..99)
//   tens  out 4  BCD tens digit
//   ones  out 4  BCD ones digit
// -----------------------------------------------------------------------------
module bin2bcd99 (
   input  logic [6:0] bin,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   assign tens = 4'(bin / 7'd10);
   assign ones = 4'(bin % 7'd10);

endmodule

// File: rtl/vend_sequencer.sv
// -----------------------------------------------------------------------------
// vend_sequencer
// Transaction controller for the vending calculator. Accepts coin pulses and
// item requests (voice / IR, round-robin arbitrated), keeps pay and item
// totals, decides purchases, drives the dispense servo and pays out change.
// Ports:
//   clock, clr                    clock and synchronous active-high reset
//   coin5, coin1                  one-cycle coin pulses (worth 5 and 1)
//   v_valid/v_item, ir_valid/ir_item  item requests from voice and IR
//   confirm, cancel               one-cycle command pulses
//   pay_total, item_total, change binary amounts 0..99
//   *_sw / *_gw                   BCD tens / ones digits of those amounts
//   en_duoji                      servo enable
//   change_pulse                  one pulse per unit of change paid
//   coin_rej, req_drop, insufficient  one-cycle event pulses
//   state                         current state, for debug
// -----------------------------------------------------------------------------
module vend_sequencer
   import vend_sequencer_pkg::*;
#(
   parameter int unsigned DISP_CYCLES    = 50_000_000,
   parameter int unsigned CHANGE_GAP     = 25_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
   parameter int unsigned PRICE0         = 3,
   parameter int unsigned PRICE1         = 5,
   parameter int unsigned PRICE2         = 8,
   parameter int unsigned PRICE3         = 10
) (
   input  logic       clock,
   input  logic       clr,
   input  logic       coin5,
   input  logic       coin1,
   input  logic       v_valid,
   input  logic [1:0] v_item,
   input  logic       ir_valid,
   input  logic [1:0] ir_item,
   input  logic       confirm,
   input  logic       cancel,
   output logic [6:0] pay_total,
   output logic [6:0] item_total,
   output logic [6:0] change,
   output logic [3:0] pay_sw,
   output logic [3:0] pay_gw,
   output logic [3:0] item_sw,
   output logic [3:0] item_gw,
   output logic [3:0] chg_sw,
   output logic [3:0] chg_gw,
   output logic       en_duoji,
   output logic       change_pulse,
   output logic       coin_rej,
   output logic       req_drop,
   output logic       insufficient,
   output logic [1:0] state
);

   vend_state_t state_reg;
   logic [6:0]  pay_reg;
   logic [6:0]  item_reg;
   logic [6:0]  chg_reg;
   logic        en_duoji_reg;
   logic        change_pulse_reg;
   logic        coin_rej_reg;
   logic        req_drop_reg;
   logic        insufficient_reg;
   logic        rr_ptr_reg;        // 0 = voice has priority, 1 = IR
   logic [31:0] tmo_cnt_reg;
   logic [31:0] disp_cnt_reg;
   logic [31:0] gap_cnt_reg;

   // Per-cycle decode of the inputs against the current totals
   logic       coin_any;
   logic [6:0] coin_amt;
   logic       coin_ok;
   logic       both_valid;
   logic       win_valid;
   logic [1:0] win_code;
   logic [6:0] win_price;
   logic       item_ok;
   logic       tmo_hit;

   function automatic logic [6:0] price_of(input logic [1:0] code);
      case (code)
         ITEM_BISCUIT: price_of = 7'(PRICE0);
         ITEM_BERRY:   price_of = 7'(PRICE1);
         ITEM_MILK:    price_of = 7'(PRICE2);
         default:      price_of = 7'(PRICE3);   // ITEM_COFFEE
      endcase
   endfunction

   always_comb begin
      coin_any   = coin5 | coin1;
      // Simultaneous coins form one combined amount so they are accepted or
      // rejected together.
      coin_amt   = (coin5 ? 7'd5 : 7'd0) + (coin1 ? 7'd1 : 7'd0);
      coin_ok    = coin_any && fits_99(pay_reg, coin_amt);
      both_valid = v_valid & ir_valid;
      win_valid  = v_valid | ir_valid;
      win_code   = (ir_valid && (!v_valid || rr_ptr_reg)) ? ir_item : v_item;
      win_price  = price_of(win_code);
      item_ok    = win_valid && fits_99(item_reg, win_price);
      // >= rather than == so a confirm landing on the terminal count only
      // postpones the refund by a cycle instead of losing it.
      tmo_hit    = (state_reg == ST_SHOP) && (tmo_cnt_reg >= 32'(TIMEOUT_CYCLES - 1));
   end

   always_ff @(posedge clock) begin
      if (clr) begin
         state_reg        <= ST_IDLE;
         pay_reg          <= '0;
         item_reg         <= '0;
         chg_reg          <= '0;
         en_duoji_reg     <= 1'b0;
         change_pulse_reg <= 1'b0;
         coin_rej_reg     <= 1'b0;
         req_drop_reg     <= 1'b0;
         insufficient_reg <= 1'b0;
         rr_ptr_reg       <= 1'b0;
         tmo_cnt_reg      <= '0;
         disp_cnt_reg     <= '0;
         gap_cnt_reg      <= '0;
      end else begin
         coin_rej_reg     <= 1'b0;
         req_drop_reg     <= 1'b0;
         insufficient_reg <= 1'b0;
         change_pulse_reg <= 1'b0;

         case (state_reg)
            ST_IDLE, ST_SHOP: begin
               if ((state_reg == ST_SHOP) && (cancel || confirm || tmo_hit)) begin
                  // A command owns the cycle: anything arriving alongside it
                  // is bounced back to the customer.
                  coin_rej_reg <= coin_any;
                  req_drop_reg <= win_valid;
                  if (cancel || !confirm) begin
                     // Refund: everything paid goes back as change.
                     chg_reg          <= pay_reg;
                     item_reg         <= '0;
                     change_pulse_reg <= (pay_reg != '0);
                     gap_cnt_reg      <= '0;
                     state_reg        <= ST_CHANGE;
                  end else if ((item_reg != '0) && (pay_reg >= item_reg)) begin
                     chg_reg      <= pay_reg - item_reg;
                     en_duoji_reg <= 1'b1;
                     disp_cnt_reg <= '0;
                     state_reg    <= ST_DISPENSE;
                  end else begin
                     insufficient_reg <= (item_reg != '0);
                     tmo_cnt_reg      <= tmo_cnt_reg + 32'd1;
                  end
               end else begin
                  coin_rej_reg <= coin_any && !coin_ok;
                  if (coin_ok) begin
                     pay_reg <= pay_reg + coin_amt;
                  end
                  req_drop_reg <= both_valid || (win_valid && !item_ok);
                  if (item_ok) begin
                     item_reg <= item_reg + win_price;
                  end
                  if (both_valid) begin
                     rr_ptr_reg <= ~rr_ptr_reg;
                  end
                  if (coin_ok || item_ok) begin
                     tmo_cnt_reg <= '0;
                     state_reg   <= ST_SHOP;
                  end else if (state_reg == ST_SHOP) begin
                     tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
                  end
               end
            end

            ST_DISPENSE: begin
               coin_rej_reg <= coin_any;
               if (disp_cnt_reg == 32'(DISP_CYCLES - 1)) begin
                  en_duoji_reg     <= 1'b0;
                  change_pulse_reg <= (chg_reg != '0);
                  gap_cnt_reg      <= '0;
                  state_reg        <= ST_CHANGE;
               end else begin
                  disp_cnt_reg <= disp_cnt_reg + 32'd1;
               end
            end

            ST_CHANGE: begin
               coin_rej_reg <= coin_any;
               if (change_pulse_reg) begin
                  // The unit shown during the pulse is paid once it ends.
                  chg_reg <= chg_reg - 7'd1;
                  if (chg_reg == 7'd1) begin
                     pay_reg   <= '0;
                     item_reg  <= '0;
                     state_reg <= ST_IDLE;
                  end else if (CHANGE_GAP == 1) begin
                     change_pulse_reg <= 1'b1;
                  end else begin
                     gap_cnt_reg <= 32'd1;
                  end
               end else if (chg_reg == '0) begin
                  pay_reg   <= '0;
                  item_reg  <= '0;
                  state_reg <= ST_IDLE;
               end else if (gap_cnt_reg >= 32'(CHANGE_GAP - 1)) begin
                  change_pulse_reg <= 1'b1;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg + 32'd1;
               end
            end

            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // BCD digits for the three seven-segment pairs
   logic [6:0] amt_arr  [3];
   logic [3:0] tens_arr [3];
   logic [3:0] ones_arr [3];

   assign amt_arr[0] = pay_reg;
   assign amt_arr[1] = item_reg;
   assign amt_arr[2] = chg_reg;

   for (genvar gi = 0; gi < 3; gi++) begin : g_bcd
      bin2bcd99 u_bcd (
         .bin  (amt_arr[gi]),
         .tens (tens_arr[gi]),
         .ones (ones_arr[gi])
      );
   end

   assign pay_sw  = tens_arr[0];
   assign pay_gw  = ones_arr[0];
   assign item_sw = tens_arr[1];
   assign item_gw = ones_arr[1];
   assign chg_sw  = tens_arr[2];
   assign chg_gw  = ones_arr[2];

   assign pay_total    = pay_reg;
   assign item_total   = item_reg;
   assign change       = chg_reg;
   assign en_duoji     = en_duoji_reg;
   assign change_pulse = change_pulse_reg;
   assign coin_rej     = coin_rej_reg;
   assign req_drop     = req_drop_reg;
   assign insufficient = insufficient_reg;
   assign state        = state_reg;

endmodule

// File: tb/tb_vend_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vend_sequencer
// Directed scenarios followed by randomized bursts, every cycle compared with
// a timestamp-based behavioural model of the vending transaction rules.
// -----------------------------------------------------------------------------
module tb_vend_sequencer;

   localparam int D = 4;    // dispense cycles
   localparam int G = 2;    // change gap
   localparam int T = 20;   // timeout cycles

   logic       clock;
   logic       clr;
   logic       coin5, coin1;
   logic       v_valid, ir_valid;
   logic [1:0] v_item, ir_item;
   logic       confirm, cancel;
   logic [6:0] pay_total, item_total, change;
   logic [3:0] pay_sw, pay_gw, item_sw, item_gw, chg_sw, chg_gw;
   logic       en_duoji, change_pulse, coin_rej, req_drop, insufficient;
   logic [1:0] state;

   vend_sequencer #(
      .DISP_CYCLES    (D),
      .CHANGE_GAP     (G),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clock        (clock),
      .clr          (clr),
      .coin5        (coin5),
      .coin1        (coin1),
      .v_valid      (v_valid),
      .v_item       (v_item),
      .ir_valid     (ir_valid),
      .ir_item      (ir_item),
      .confirm      (confirm),
      .cancel       (cancel),
      .pay_total    (pay_total),
      .item_total   (item_total),
      .change       (change),
      .pay_sw       (pay_sw),
      .pay_gw       (pay_gw),
      .item_sw      (item_sw),
      .item_gw      (item_gw),
      .chg_sw       (chg_sw),
      .chg_gw       (chg_gw),
      .en_duoji     (en_duoji),
      .change_pulse (change_pulse),
      .coin_rej     (coin_rej),
      .req_drop     (req_drop),
      .insufficient (insufficient),
      .state        (state)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int n_pulse_obs = 0;
   int n_en_obs    = 0;

   // ---------------- reference model (phase + timestamps) ----------------
   int m_phase;          // 0 idle, 1 shop, 2 dispense, 3 change
   int m_pay, m_item, m_chg;
   bit m_ptr_ir;
   int m_quiet_from;     // first cycle of the current SHOP quiet stretch
   int m_disp_start;
   int m_chg_start, m_chg_amt;
   int e_rej, e_drop, e_insuf, e_pulse;

   function automatic int price(input int code);
      case (code)
         0: return 3;
         1: return 5;
         2: return 8;
         default: return 10;
      endcase
   endfunction

   function automatic void enter_change(input int start, input int amt);
      m_phase     = 3;
      m_chg_start = start;
      m_chg_amt   = amt;
      m_chg       = amt;
      e_pulse     = (amt > 0) ? 1 : 0;
   endfunction

   // Consumes the inputs of cycle 'cyc', leaves expectations for cycle cyc+1.
   function automatic void model_step();
      int nc, camt, k, done_at, wcode;
      bit wv, accepted, tmo;
      nc = cyc + 1;
      e_rej = 0; e_drop = 0; e_insuf = 0; e_pulse = 0;
      if (clr) begin
         m_phase = 0; m_pay = 0; m_item = 0; m_chg = 0; m_ptr_ir = 0;
         return;
      end
      camt = (coin5 ? 5 : 0) + (coin1 ? 1 : 0);
      if (m_phase == 2) begin
         e_rej = (camt > 0);
         if (nc == m_disp_start + D) enter_change(nc, m_chg);
      end else if (m_phase == 3) begin
         e_rej = (camt > 0);
         k = nc - m_chg_start;
         done_at = (m_chg_amt == 0) ? 1 : (m_chg_amt - 1) * G + 1;
         if (k >= done_at) begin
            m_phase = 0; m_pay = 0; m_item = 0; m_chg = 0;
         end else begin
            e_pulse = (k % G == 0);
            m_chg   = m_chg_amt - (k + G - 1) / G;
         end
      end else begin
         tmo = (m_phase == 1) && (cyc - m_quiet_from >= T - 1);
         if ((m_phase == 1) && (cancel || confirm || tmo)) begin
            e_rej  = (camt > 0);
            e_drop = (v_valid || ir_valid);
            if (cancel || !confirm) begin
               m_item = 0;
               enter_change(nc, m_pay);
            end else if (m_item > 0 && m_pay >= m_item) begin
               m_phase = 2; m_disp_start = nc; m_chg = m_pay - m_item;
            end else begin
               e_insuf = (m_item > 0);
            end
         end else begin
            accepted = 0;
            if (camt > 0) begin
               if (m_pay + camt > 99) e_rej = 1;
               else begin m_pay += camt; accepted = 1; end
            end
            wv = 0; wcode = 0;
            if (v_valid && ir_valid) begin
               wv = 1; e_drop = 1;
               wcode = m_ptr_ir ? int'(ir_item) : int'(v_item);
               m_ptr_ir = !m_ptr_ir;
            end else if (v_valid) begin
               wv = 1; wcode = int'(v_item);
            end else if (ir_valid) begin
               wv = 1; wcode = int'(ir_item);
            end
            if (wv) begin
               if (m_item + price(wcode) > 99) e_drop = 1;
               else begin m_item += price(wcode); accepted = 1; end
            end
            if (accepted) begin m_phase = 1; m_quiet_from = nc; end
         end
      end
   endfunction

   // ---------------- checking ----------------
   function automatic void chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endfunction

   function automatic void compare_all();
      chk("state", 32'(state), m_phase);
      chk("pay_total", 32'(pay_total), m_pay);
      chk("item_total", 32'(item_total), m_item);
      chk("change", 32'(change), m_chg);
      chk("pay_sw", 32'(pay_sw), m_pay / 10);
      chk("pay_gw", 32'(pay_gw), m_pay % 10);
      chk("item_sw", 32'(item_sw), m_item / 10);
      chk("item_gw", 32'(item_gw), m_item % 10);
      chk("chg_sw", 32'(chg_sw), m_chg / 10);
      chk("chg_gw", 32'(chg_gw), m_chg % 10);
      chk("en_duoji", 32'(en_duoji), (m_phase == 2) ? 1 : 0);
      chk("change_pulse", 32'(change_pulse), e_pulse);
      chk("coin_rej", 32'(coin_rej), e_rej);
      chk("req_drop", 32'(req_drop), e_drop);
      chk("insufficient", 32'(insufficient), e_insuf);
   endfunction

   task automatic cycle(input bit c5, input bit c1, input bit vv, input logic [1:0] vi,
                        input bit iv, input logic [1:0] ii, input bit cf, input bit cn,
                        input bit cl);
      coin5 = c5; coin1 = c1; v_valid = vv; v_item = vi;
      ir_valid = iv; ir_item = ii; confirm = cf; cancel = cn; clr = cl;
      model_step();
      @(posedge clock);
      #1;
      cyc++;
      compare_all();
      if (change_pulse === 1'b1) n_pulse_obs++;
      if (en_duoji === 1'b1) n_en_obs++;
      $display("cyc %0d st=%0d pay=%0d item=%0d chg=%0d en=%0b pulse=%0b rej=%0b drop=%0b insuf=%0b",
               cyc, state, pay_total, item_total, change, en_duoji, change_pulse,
               coin_rej, req_drop, insufficient);
   endtask

   task automatic nop();
      cycle(0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
   endtask

   task automatic do_reset();
      cycle(0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 1);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int i;
      i = 0;
      while (state !== 2'd0 && i < budget) begin
         nop();
         i++;
      end
      chk(tag, 32'(state), 0);
   endtask

   function automatic bit pr(input int pct);
      return $urandom_range(0, 99) < pct;
   endfunction

   int lvl;

   initial begin
      coin5 = 0; coin1 = 0; v_valid = 0; v_item = 0; ir_valid = 0; ir_item = 0;
      confirm = 0; cancel = 0; clr = 1;
      m_phase = 0; m_pay = 0; m_item = 0; m_chg = 0; m_ptr_ir = 0;
      m_quiet_from = 0; m_disp_start = 0; m_chg_start = 0; m_chg_amt = 0;

      // Reset state
      do_reset();
      do_reset();
      chk("rst_state", 32'(state), 0);
      chk("rst_pay", 32'(pay_total), 0);
      chk("rst_en", 32'(en_duoji), 0);
      chk("rst_chg_gw", 32'(chg_gw), 0);

      // 1. Underpay then complete
      cycle(1, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
      cycle(0, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0);
      chk("s1_pay6", 32'(pay_total), 6);
      cycle(0, 0, 1, 2'd2, 0, 2'd0, 0, 0, 0);
      chk("s1_item8", 32'(item_total), 8);
      cycle(0, 0, 0, 2'd0, 0, 2'd0, 1, 0, 0);
      chk("s1_insufficient", 32'(insufficient), 1);
      chk("s1_still_shop", 32'(state), 1);
      cycle(1, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
      chk("s1_pay11", 32'(pay_total), 11);
      n_pulse_obs = 0; n_en_obs = 0;
      cycle(0, 0, 0, 2'd0, 0, 2'd0, 1, 0, 0);
      chk("s1_dispense", 32'(state), 2);
      wait_idle(40, "s1_idle");
      chk("s1_en_cycles", n_en_obs, 4);
      chk("s1_pulses", n_pulse_obs, 3);
      chk("s1_pay_cleared", 32'(pay_total), 0);

      // 2. Arbitration
      do_reset();
      cycle(0, 0, 1, 2'd0, 1, 2'd1, 0, 0, 0);
      chk("s2_voice_wins", 32'(item_total), 3);
      chk("s2_drop1", 32'(req_drop), 1);
      cycle(0, 0, 1, 2'd0, 1, 2'd1, 0, 0, 0);
      chk("s2_ir_wins", 32'(item_total), 8);
      chk("s2_drop2", 32'(req_drop), 1);

      // 3. Overflow
      do_reset();
      for (int i = 0; i < 19; i++) cycle(1, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
      chk("s3_pay95", 32'(pay_total), 95);
      cycle(1, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
      chk("s3_coin_rej", 32'(coin_rej), 1);
      chk("s3_pay_kept", 32'(pay_total), 95);
      cycle(0, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0);
      chk("s3_pay96", 32'(pay_total), 96);
      for (int i = 0; i < 9; i++) cycle(0, 0, 1, 2'd3, 0, 2'd0, 0, 0, 0);
      cycle(0, 0, 1, 2'd1, 0, 2'd0, 0, 0, 0);
      chk("s3_item95", 32'(item_total), 95);
      cycle(0, 0, 0, 2'd0, 1, 2'd2, 0, 0, 0);
      chk("s3_item_drop", 32'(req_drop), 1);
      chk("s3_item_kept", 32'(item_total), 95);

      // 4. Cancel
      do_reset();
      cycle(1, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
      cycle(0, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0);
      cycle(0, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0);
      cycle(0, 0, 1, 2'd1, 0, 2'd0, 0, 0, 0);
      n_pulse_obs = 0; n_en_obs = 0;
      cycle(0, 0, 0, 2'd0, 0, 2'd0, 0, 1, 0);
      chk("s4_change_state", 32'(state), 3);
      chk("s4_change7", 32'(change), 7);
      cycle(0, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0);
      chk("s4_coin_rej", 32'(coin_rej), 1);
      wait_idle(40, "s4_idle");
      chk("s4_pulses", n_pulse_obs, 7);
      chk("s4_no_en", n_en_obs, 0);

      // 5. Timeout
      do_reset();
      n_pulse_obs = 0;
      cycle(0, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0);
      for (int i = 0; i < 19; i++) nop();
      chk("s5_still_shop", 32'(state), 1);
      nop();
      chk("s5_change", 32'(state), 3);
      chk("s5_first_pulse", 32'(change_pulse), 1);
      wait_idle(20, "s5_idle");
      chk("s5_pulses", n_pulse_obs, 1);

      // 6. Reset mid-dispense
      do_reset();
      cycle(1, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
      cycle(1, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
      cycle(0, 0, 0, 2'd0, 1, 2'd0, 0, 0, 0);
      cycle(0, 0, 0, 2'd0, 0, 2'd0, 1, 0, 0);
      nop();
      chk("s6_in_dispense", 32'(en_duoji), 1);
      n_pulse_obs = 0;
      do_reset();
      chk("s6_en_low", 32'(en_duoji), 0);
      chk("s6_idle", 32'(state), 0);
      chk("s6_pay0", 32'(pay_total), 0);
      chk("s6_chg_gw0", 32'(chg_gw), 0);
      for (int i = 0; i < 8; i++) nop();
      chk("s6_no_pulses", n_pulse_obs, 0);

      // Randomized bursts of varying activity; quiet bursts exercise timeout
      for (int b = 0; b < 40; b++) begin
         lvl = int'($urandom_range(0, 3));
         for (int i = 0; i < 60; i++) begin
            cycle(pr(lvl * 5), pr(lvl * 6), pr(lvl * 5), 2'($urandom_range(0, 3)),
                  pr(lvl * 5), 2'($urandom_range(0, 3)), pr(lvl * 2), pr(lvl),
                  ($urandom_range(0, 399) == 0));
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
